// File: rtl/mem_write_checker.sv
// Store-sequence checker: watches a memory write port and compares each store
// against a programmed table of expected {address, data} pairs in order.
module mem_write_checker #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT     = 40,
  parameter int unsigned IGNORE_ADDR = 96
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mem_write,
  input  logic [ADDR_W-1:0]        data_adr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [ADDR_W-1:0]        cfg_adr,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_count,
  input  logic                     start,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [1:0]               fail_code,
  output logic [ADDR_W-1:0]        fail_adr,
  output logic [$clog2(DEPTH):0]   match_count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0]     T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IGN_ADR = ADDR_W'(IGNORE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_exp_adr  [DEPTH];
  logic [DATA_W-1:0]   r_exp_data [DEPTH];
  logic [CW-1:0]       r_count, w_count_nxt;
  logic [CW-1:0]       r_match, w_match_nxt;
  logic [TW-1:0]       r_timer, w_timer_nxt;
  logic [1:0]          r_code, w_code_nxt;
  logic [ADDR_W-1:0]   r_fadr, w_fadr_nxt;
  logic [CW-1:0]       w_count_sat;
  logic                w_hit;

  assign w_count_sat = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
  assign w_hit = mem_write
              && (data_adr   == r_exp_adr[r_match[IW-1:0]])
              && (write_data == r_exp_data[r_match[IW-1:0]]);

  // Table is frozen while a check is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_exp_adr[i]  <= '0;
        r_exp_data[i] <= '0;
      end
    end else if (cfg_we && r_state != S_RUN) begin
      r_exp_adr[cfg_idx]  <= cfg_adr;
      r_exp_data[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_match <= '0;
      r_timer <= '0;
      r_code  <= '0;
      r_fadr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_match <= w_match_nxt;
      r_timer <= w_timer_nxt;
      r_code  <= w_code_nxt;
      r_fadr  <= w_fadr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_match_nxt = r_match;
    w_timer_nxt = r_timer;
    w_code_nxt  = r_code;
    w_fadr_nxt  = r_fadr;
    case (r_state)
      S_RUN: begin
        w_timer_nxt = r_timer + 1'b1;
        if (w_hit) begin
          w_match_nxt = r_match + 1'b1;
          if ((r_match + 1'b1) == r_count) w_state_nxt = S_PASS;
        end else if (mem_write && data_adr != IGN_ADR) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = 2'b01;
          w_fadr_nxt  = data_adr;
        end
        // Timeout only fires when no pass/mismatch was decided this cycle.
        if (w_state_nxt == S_RUN && r_timer == T_LAST) begin
          w_state_nxt = S_FAIL;
          w_code_nxt  = 2'b10;
        end
      end
      default: begin
        if (start) begin
          w_count_nxt = w_count_sat;
          w_match_nxt = '0;
          w_timer_nxt = '0;
          w_code_nxt  = '0;
          w_fadr_nxt  = '0;
          w_state_nxt = (w_count_sat == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  assign pass        = (r_state == S_PASS);
  assign fail        = (r_state == S_FAIL);
  assign done        = pass | fail;
  assign fail_code   = r_code;
  assign fail_adr    = r_fadr;
  assign match_count = r_match;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed table-driven bench for mem_write_checker with hand-written
// timeout and reset sequences.
module tb_mem_write_checker;

  logic        clk;
  logic        reset_n;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_adr;
  logic [31:0] cfg_data;
  logic [3:0]  cfg_count;
  logic        start;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [31:0] fail_adr;
  logic [3:0]  match_count;

  int n_total = 0;
  int n_pass  = 0;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(8), .TIMEOUT(40), .IGNORE_ADDR(96)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .done(done),
    .pass(pass), .fail(fail), .fail_code(fail_code), .fail_adr(fail_adr),
    .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // er: expected result 0 = none, 1 = pass, 2 = fail
  typedef struct {
    logic        cwe;
    logic [2:0]  ci;
    logic [31:0] ca, cd;
    logic [3:0]  cc;
    logic        st, mw;
    logic [31:0] a, d;
    logic [1:0]  er, ec;
    logic [31:0] efa;
    logic [3:0]  emc;
  } vec_t;

  function automatic vec_t NOP();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t CFG(input logic [2:0] i, input logic [31:0] a, d);
    vec_t v = NOP();
    v.cwe = 1'b1; v.ci = i; v.ca = a; v.cd = d;
    return v;
  endfunction

  function automatic vec_t START(input logic [3:0] c);
    vec_t v = NOP();
    v.st = 1'b1; v.cc = c;
    return v;
  endfunction

  function automatic vec_t ST(input logic [31:0] a, d);
    vec_t v = NOP();
    v.mw = 1'b1; v.a = a; v.d = d;
    return v;
  endfunction

  function automatic vec_t X(input vec_t vi, input logic [1:0] er, ec,
                             input logic [31:0] efa, input logic [3:0] emc);
    vec_t v = vi;
    v.er = er; v.ec = ec; v.efa = efa; v.emc = emc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] er, ec,
                         input logic [31:0] efa, input logic [3:0] emc);
    chk({tag, ".done"},  32'(done),        32'(er != 2'd0));
    chk({tag, ".pass"},  32'(pass),        32'(er == 2'd1));
    chk({tag, ".fail"},  32'(fail),        32'(er == 2'd2));
    chk({tag, ".code"},  32'(fail_code),   32'(ec));
    chk({tag, ".fadr"},  fail_adr,         efa);
    chk({tag, ".mcnt"},  32'(match_count), 32'(emc));
  endtask

  task automatic drive(input vec_t v);
    cfg_we = v.cwe; cfg_idx = v.ci; cfg_adr = v.ca; cfg_data = v.cd;
    cfg_count = v.cc; start = v.st; mem_write = v.mw; data_adr = v.a; write_data = v.d;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    chk_all(tag, v.er, v.ec, v.efa, v.emc);
  endtask

  vec_t vq[$];

  initial begin
    reset_n = 1'b0;
    drive(NOP());
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 2'd0, 32'd0, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // single entry: ignored store then match; held in PASS; mismatch
    vq.push_back(X(CFG(0, 100, 7), 0, 0, 0, 0));
    vq.push_back(X(START(1),       0, 0, 0, 0));
    vq.push_back(X(ST(96, 3),      0, 0, 0, 0));
    vq.push_back(X(ST(100, 7),     1, 0, 0, 1));
    vq.push_back(X(ST(5, 5),       1, 0, 0, 1));
    vq.push_back(X(START(1),       0, 0, 0, 0));
    vq.push_back(X(ST(100, 8),     2, 1, 100, 0));
    // three entries in order, then out of order
    vq.push_back(X(CFG(0, 80, 1),  2, 1, 100, 0));
    vq.push_back(X(CFG(1, 84, 2),  2, 1, 100, 0));
    vq.push_back(X(CFG(2, 100, 7), 2, 1, 100, 0));
    vq.push_back(X(START(3),       0, 0, 0, 0));
    vq.push_back(X(ST(80, 1),      0, 0, 0, 1));
    vq.push_back(X(NOP(),          0, 0, 0, 1));
    vq.push_back(X(ST(84, 2),      0, 0, 0, 2));
    vq.push_back(X(ST(100, 7),     1, 0, 0, 3));
    vq.push_back(X(START(3),       0, 0, 0, 0));
    vq.push_back(X(ST(84, 2),      2, 1, 84, 0));
    // cfg write and restart while running are ignored
    vq.push_back(X(START(3),       0, 0, 0, 0));
    vq.push_back(X(ST(80, 1),      0, 0, 0, 1));
    begin
      vec_t v = CFG(1, 200, 9);
      v.st = 1'b1; v.cc = 4'd1;
      vq.push_back(X(v,            0, 0, 0, 1));
    end
    vq.push_back(X(ST(84, 2),      0, 0, 0, 2));
    vq.push_back(X(ST(100, 7),     1, 0, 0, 3));
    // count 9 saturates to 8; entries 3..7 are still zero from reset
    vq.push_back(X(START(9),       0, 0, 0, 0));
    vq.push_back(X(ST(80, 1),      0, 0, 0, 1));
    vq.push_back(X(ST(84, 2),      0, 0, 0, 2));
    vq.push_back(X(ST(100, 7),     0, 0, 0, 3));
    vq.push_back(X(ST(0, 0),       0, 0, 0, 4));
    vq.push_back(X(ST(0, 0),       0, 0, 0, 5));
    vq.push_back(X(ST(0, 0),       0, 0, 0, 6));
    vq.push_back(X(ST(0, 0),       0, 0, 0, 7));
    vq.push_back(X(ST(0, 0),       1, 0, 0, 8));

    for (int i = 0; i < vq.size(); i++) apply(vq[i], $sformatf("v%0d", i));

    // timeout at edge 40 after start
    apply(X(CFG(0, 100, 7), 1, 0, 0, 8), "to.cfg");
    apply(X(START(1), 0, 0, 0, 0), "to.start");
    for (int k = 1; k < 40; k++) apply(X(NOP(), 0, 0, 0, 0), $sformatf("to.e%0d", k));
    apply(X(NOP(), 2, 2, 0, 0), "to.e40");

    // final match on the timeout edge wins
    apply(X(START(1), 0, 0, 0, 0), "tm.start");
    for (int k = 1; k < 40; k++) apply(X(NOP(), 0, 0, 0, 0), $sformatf("tm.e%0d", k));
    apply(X(ST(100, 7), 1, 0, 0, 1), "tm.e40");

    // mismatch on the timeout edge reports code 01
    apply(X(START(1), 0, 0, 0, 0), "tx.start");
    for (int k = 1; k < 40; k++) apply(X(NOP(), 0, 0, 0, 0), $sformatf("tx.e%0d", k));
    apply(X(ST(50, 0), 2, 1, 50, 0), "tx.e40");

    // asynchronous reset mid-run after one match
    apply(X(CFG(1, 84, 2), 2, 1, 50, 0), "rs.cfg");
    apply(X(START(2), 0, 0, 0, 0), "rs.start");
    apply(X(ST(100, 7), 0, 0, 0, 1), "rs.m1");
    @(negedge clk);
    drive(NOP());
    reset_n = 1'b0;
    #1;
    chk_all("rs.async", 2'd0, 2'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("rs.held", 2'd0, 2'd0, 32'd0, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    // cleared table: entry 0 is {0,0}
    apply(X(START(1), 0, 0, 0, 0), "rs.s1");
    apply(X(ST(0, 0), 1, 0, 0, 1), "rs.zero");
    apply(X(CFG(0, 100, 7), 1, 0, 0, 1), "rs.cfg2");
    apply(X(START(1), 0, 0, 0, 0), "rs.s2");
    apply(X(ST(100, 7), 1, 0, 0, 1), "rs.pass");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
